// File: rtl/exp_pkg.sv
// exp_pkg: shared Q-format constants, coefficients and helpers for the e^x unit
package exp_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC = 12;
  localparam logic signed [47:0] LOG2E = 48'sd94548;
  localparam logic signed [47:0] LN2 = 48'sd181704;
  // Horner coefficients 1, 1, 1/2, 1/6, 1/24, 1/120 in Q.20
  localparam logic signed [47:0] C0 = 48'sd1048576;
  localparam logic signed [47:0] C1 = 48'sd1048576;
  localparam logic signed [47:0] C2 = 48'sd524288;
  localparam logic signed [47:0] C3 = 48'sd174763;
  localparam logic signed [47:0] C4 = 48'sd43691;
  localparam logic signed [47:0] C5 = 48'sd8738;
  localparam logic [WIDTH-1:0] MAX_OUT = 16'h7FFF;
  typedef logic signed [WIDTH-1:0] q3_12_t;
  function automatic logic signed [47:0] mac(input logic signed [47:0] c, a, r);
    return c + ((a * r) >>> 18);
  endfunction
endpackage

// File: rtl/exp_core.sv
// exp_core: combinational e^x for signed Q3.12; EXP_ROUND_EN rounds the final shift half-up
module exp_core
  import exp_pkg::*;
(
  input  q3_12_t           x,
  output logic [WIDTH-1:0] y
);
  logic signed [47:0] xs, t, k, r, p, sh;
  logic [5:0] s;
  always_comb begin
    xs = 48'(x);
    // k = round(x*log2e) keeps r within +-ln2/2, where the degree-5 series error is far below 1 LSB
    t = xs * LOG2E + (48'sd1 <<< 27);
    k = t >>> 28;
    r = (xs <<< 6) - k * LN2;
    p = mac(C0, mac(C1, mac(C2, mac(C3, mac(C4, C5, r), r), r), r), r);
    s = 6'(48'sd8 - k);
`ifdef EXP_ROUND_EN
    sh = (p + (48'sd1 <<< (s - 6'd1))) >>> s;
`else
    sh = p >>> s;
`endif
    y = (k > 48'sd3 || sh > 48'sd32767) ? MAX_OUT : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/exp_fixed.sv
// exp_fixed: N_STAGE-deep pipelined e^x with valid tracking; define EXP_ROUND_EN for rounded output
module exp_fixed #(
  parameter int N_STAGE = 2,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] output_data,
  output logic             write_enable
);
  import exp_pkg::*;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] stage [N_STAGE];
  logic [N_STAGE-1:0] vld;
  exp_core u_core (.x(data), .y(y));
  always_ff @(posedge CLK)
    if (RST) begin
      for (int i = 0; i < N_STAGE; i++) stage[i] <= '0;
      vld <= '0;
    end else begin
      stage[0] <= y;
      for (int i = 1; i < N_STAGE; i++) stage[i] <= stage[i-1];
      vld <= (vld << 1) | N_STAGE'(1);
    end
  assign output_data = stage[N_STAGE-1];
  assign write_enable = vld[N_STAGE-1];
endmodule

// File: tb/tb_exp_fixed.sv
// tb_exp_fixed: directed vectors, reset behaviour and a full input sweep against a real-valued e^x model
module tb_exp_fixed;
  localparam int N = 2;
`ifdef EXP_ROUND_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 2;
`endif
  typedef struct { logic [15:0] x; int e; int t; } vec_t;
  localparam int NV = 11;
  vec_t vecs [NV] = '{
    '{16'h1333, 13599, TOL},
    '{16'h0800, 6753, TOL},
    '{16'h1000, 11134, TOL},
    '{16'hF000, 1507, TOL},
    '{16'h3000, 32767, 0},
    '{16'h7FFF, 32767, 0},
    '{16'h2147, 32767, 0},
    '{16'h2145, 32765, TOL},
    '{16'h8000, 1, 1},
    '{16'hC000, 75, TOL},
    '{16'h0000, 4096, 0}
  };
  logic clk = 0, rst = 1, we;
  logic [15:0] data = 0, out;
  int errors = 0, checks = 0;
  exp_fixed #(.N_STAGE(N)) dut (.CLK(clk), .RST(rst), .data(data), .output_data(out), .write_enable(we));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", tag, got, exp, tol);
    end
  endtask
  function automatic int ref_exp(input logic [15:0] c);
    real v;
    v = $exp($itor($signed(c)) / 4096.0) * 4096.0;
    if (v >= 32767.0) return 32767;
    return $rtoi(v + 0.5);
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    check("reset out", int'(out), 0);
    check("reset we", int'(we), 0);
    rst = 0;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      check($sformatf("we after release %0d", i), int'(we), (i == N) ? 1 : 0);
    end
    check("exp(0)", int'(out), 4096);
    for (int c = 0; c < NV + N; c++) begin
      if (c >= N) check($sformatf("vec x=%h", vecs[c-N].x), int'(out), vecs[c-N].e, vecs[c-N].t);
      if (c < NV) data = vecs[c].x;
      @(negedge clk);
    end
    data = 16'h1000;
    repeat (N) @(negedge clk);
    check("we streaming", int'(we), 1);
    rst = 1;
    @(negedge clk);
    check("mid reset out", int'(out), 0);
    check("mid reset we", int'(we), 0);
    rst = 0;
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      check($sformatf("we after mid reset %0d", i), int'(we), (i == N) ? 1 : 0);
    end
    check("exp(1) after reset", int'(out), 11134, TOL);
    for (int c = 0; c < 65536 + N; c++) begin
      if (c >= N) check($sformatf("sweep x=%h", 16'(c - N)), int'(out), ref_exp(16'(c - N)), TOL);
      if (c < 65536) data = 16'(c);
      @(negedge clk);
    end
    check("we end", int'(we), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
